// File: rtl/crypto1_key_collector.sv
// Collects the first recovered key from a Crypto1Core array over the winning
// core's serial KEY_DATA/KEY_CLK link and reports it, or reports exhaustion
// when every core has finished without a key.
module crypto1_key_collector #(
    parameter int unsigned NCORES = 16,
    parameter int unsigned KEY_W  = 48
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    input  logic [NCORES-1:0]            CORE_DONE,
    input  logic [NCORES-1:0]            CORE_KEY_VALID,
    input  logic [NCORES-1:0]            CORE_KEY_DATA,
    output logic [NCORES-1:0]            CORE_KEY_CLK,
    output logic [KEY_W-1:0]             KEY,
    output logic                         KEY_FOUND,
    output logic [$clog2(NCORES):0]      CORE_IDX,
    output logic                         SEARCH_DONE,
    output logic                         BUSY,
    input  logic                         ACK
);

    localparam int unsigned IDX_W = $clog2(NCORES) + 1;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [NCORES-1:0]   sel_oh;
    logic [IDX_W-1:0]    sel_idx;
    logic [NCORES-1:0]   consumed;
    logic                en_d1;
    logic                en_d2;

    logic [NCORES-1:0]   avail;
    logic [NCORES-1:0]   first_oh;
    logic [IDX_W-1:0]    first_idx;
    logic                key_bit;
    logic                all_done;

    // Lowest-index unconsumed core with a key, as one-hot and as index
    always_comb begin
        avail     = CORE_KEY_VALID & ~consumed;
        first_oh  = avail & (~avail + NCORES'(1));
        first_idx = '0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            if (first_oh[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    assign key_bit  = |(CORE_KEY_DATA & sel_oh);
    assign all_done = &CORE_DONE;

    // Control FSM, serial key capture and registered host-side outputs
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state        <= SCAN;
            bit_cnt      <= '0;
            sel_oh       <= '0;
            sel_idx      <= '0;
            consumed     <= '0;
            en_d1        <= 1'b0;
            en_d2        <= 1'b0;
            CORE_KEY_CLK <= '0;
            KEY          <= '0;
            KEY_FOUND    <= 1'b0;
            CORE_IDX     <= '0;
            SEARCH_DONE  <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            // Core data lags the shift enable by two cycles
            en_d1 <= |CORE_KEY_CLK;
            en_d2 <= en_d1;
            if (en_d2) begin
                KEY <= {KEY[KEY_W-2:0], key_bit};
            end

            case (state)
                SCAN: begin
                    if (|avail) begin
                        sel_oh       <= first_oh;
                        sel_idx      <= first_idx;
                        CORE_KEY_CLK <= first_oh;
                        bit_cnt      <= '0;
                        BUSY         <= 1'b1;
                        state        <= SHIFT;
                    end else if (all_done) begin
                        SEARCH_DONE <= 1'b1;
                        KEY_FOUND   <= 1'b0;
                        state       <= REPORT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == CNT_W'(KEY_W - 1)) begin
                        CORE_KEY_CLK <= '0;
                        state        <= DRAIN;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Last bit is shifted in on this edge
                    if (en_d2 && !en_d1) begin
                        KEY_FOUND   <= 1'b1;
                        SEARCH_DONE <= 1'b1;
                        CORE_IDX    <= sel_idx;
                        consumed    <= consumed | sel_oh;
                        BUSY        <= 1'b0;
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    if (ACK) begin
                        SEARCH_DONE <= 1'b0;
                        KEY_FOUND   <= 1'b0;
                        KEY         <= '0;
                        state       <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto1_key_collector.sv
// Directed bench for crypto1_key_collector with a cycle-offset reference model
// and a bank of simple serial core models.
module tb_crypto1_key_collector;

    localparam int unsigned NC = 16;
    localparam int unsigned KW = 48;

    logic            clk;
    logic            rstn;
    logic [NC-1:0]   core_done;
    logic [NC-1:0]   core_valid;
    logic [NC-1:0]   cdata;
    logic [NC-1:0]   kclk;
    logic [KW-1:0]   key;
    logic            found;
    logic [4:0]      idx;
    logic            sdone;
    logic            busy;
    logic            ack;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    crypto1_key_collector #(.NCORES(NC), .KEY_W(KW)) dut (
        .CLK            (clk),
        .RESETn         (rstn),
        .CORE_DONE      (core_done),
        .CORE_KEY_VALID (core_valid),
        .CORE_KEY_DATA  (cdata),
        .CORE_KEY_CLK   (kclk),
        .KEY            (key),
        .KEY_FOUND      (found),
        .CORE_IDX       (idx),
        .SEARCH_DONE    (sdone),
        .BUSY           (busy),
        .ACK            (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Core models: KEY_DATA shows key bit 47-i two cycles after KEY_CLK cycle i
    logic [KW-1:0] key_table [NC];
    logic [KW-1:0] sr        [NC];
    logic [NC-1:0] cdly;
    logic          core_rst;

    always @(posedge clk) begin
        if (core_rst) begin
            for (int k = 0; k < NC; k++) sr[k] <= key_table[k];
            cdly  <= '0;
            cdata <= '0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                cdly[k] <= kclk[k];
                if (cdly[k]) begin
                    cdata[k] <= sr[k][KW-1];
                    sr[k]    <= sr[k] << 1;
                end
            end
        end
    end

    // Reference model: transfer phases derived from the edge the key was selected
    int            m_mode = 0;   // 0 scan, 1 transfer, 2 report
    int            m_e    = 0;
    int            m_sel  = 0;
    logic [KW-1:0] m_key  = '0;
    logic [NC-1:0] m_consumed = '0;
    logic          m_found = 1'b0;
    logic          m_sdone = 1'b0;
    logic [4:0]    m_idx   = '0;

    always begin
        logic [NC-1:0] avail;
        logic [NC-1:0] e_kclk;
        logic [KW-1:0] e_key;
        int            n;
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            m_mode = 0; m_consumed = '0; m_found = 1'b0; m_sdone = 1'b0; m_idx = '0;
        end else begin
            case (m_mode)
                0: begin
                    avail = core_valid & ~m_consumed;
                    if (avail != '0) begin
                        for (int k = NC - 1; k >= 0; k--) if (avail[k]) m_sel = k;
                        m_e    = cyc;
                        m_key  = key_table[m_sel];
                        m_mode = 1;
                    end else if (core_done == '1) begin
                        m_mode = 2; m_sdone = 1'b1; m_found = 1'b0;
                    end
                end
                1: if (cyc == m_e + 50) begin
                    m_mode = 2; m_found = 1'b1; m_sdone = 1'b1;
                    m_idx = 5'(m_sel);
                    m_consumed[m_sel] = 1'b1;
                end
                default: if (ack) begin
                    m_mode = 0; m_found = 1'b0; m_sdone = 1'b0;
                end
            endcase
        end
        e_kclk = (m_mode == 1 && cyc - m_e <= 47) ? (NC'(1) << m_sel) : '0;
        if (m_mode == 1) begin
            n = cyc - m_e - 2;
            if (n < 0) n = 0;
            e_key = (n == 0) ? '0 : (m_key >> (KW - n));
        end else begin
            e_key = m_found ? m_key : '0;
        end
        #2;
        chk("core_key_clk", 64'(kclk), 64'(e_kclk));
        chk("onehot0_key_clk", 64'($onehot0(kclk)), 64'd1);
        chk("key", 64'(key), 64'(e_key));
        chk("key_found", 64'(found), 64'(m_found));
        chk("search_done", 64'(sdone), 64'(m_sdone));
        chk("busy", 64'(busy), 64'(m_mode == 1));
        chk("core_idx", 64'(idx), 64'(m_idx));
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; core_rst = 1'b1;
        @(negedge clk);
        rstn = 1'b1; core_rst = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
    endtask

    task automatic wait_found(input string name);
        int n;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(found), 64'd1);
    endtask

    initial begin
        int t0;
        rstn = 1'b0; core_rst = 1'b1; ack = 1'b0;
        core_done = '0; core_valid = '0;
        for (int k = 0; k < NC; k++) key_table[k] = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1; core_rst = 1'b0;
        chk("reset_key", 64'(key), 64'd0);
        chk("reset_found", 64'(found), 64'd0);
        chk("reset_kclk", 64'(kclk), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // Single key from core 3
        key_table[3] = 48'hA5A5_5A5A_C3C3;
        do_reset();
        repeat (3) @(negedge clk);
        t0 = cyc;
        core_valid[3] = 1'b1;
        @(negedge clk);
        chk("t1_kclk_first", 64'(kclk), 64'h0008);
        repeat (47) @(negedge clk);
        chk("t1_kclk_last", 64'(kclk), 64'h0008);
        @(negedge clk);
        chk("t1_kclk_off", 64'(kclk), 64'h0000);
        @(negedge clk);
        chk("t1_found_early", 64'(found), 64'd0);
        @(negedge clk);
        chk("t1_latency", 64'(cyc - t0), 64'd51);
        chk("t1_key", 64'(key), 64'hA5A5_5A5A_C3C3);
        chk("t1_found", 64'(found), 64'd1);
        chk("t1_idx", 64'(idx), 64'd3);
        chk("t1_sdone", 64'(sdone), 64'd1);
        pulse_ack();
        chk("t1_ack_key", 64'(key), 64'd0);
        core_valid = '0;
        do_reset();

        // Exhausted search
        core_done = '1;
        @(negedge clk);
        chk("t2_sdone", 64'(sdone), 64'd1);
        chk("t2_found", 64'(found), 64'd0);
        repeat (3) @(negedge clk);
        pulse_ack();
        chk("t2_after_ack", 64'(sdone), 64'd0);
        @(negedge clk);
        chk("t2_reassert", 64'(sdone), 64'd1);
        core_done = '0;
        do_reset();

        // Simultaneous valids on cores 5 and 9
        key_table[5] = 48'h1234_5678_9ABC;
        key_table[9] = 48'hFEDC_BA98_7654;
        do_reset();
        core_valid[5] = 1'b1; core_valid[9] = 1'b1;
        wait_found("t3_wait5");
        chk("t3_idx5", 64'(idx), 64'd5);
        chk("t3_key5", 64'(key), 64'h1234_5678_9ABC);
        pulse_ack();
        wait_found("t3_wait9");
        chk("t3_idx9", 64'(idx), 64'd9);
        chk("t3_key9", 64'(key), 64'hFEDC_BA98_7654);
        pulse_ack();
        core_valid = '0;
        do_reset();

        // Reset in the middle of a transfer
        key_table[2] = 48'h0F0F_1E1E_8001;
        do_reset();
        core_valid[2] = 1'b1;
        repeat (21) @(negedge clk);
        rstn = 1'b0; core_rst = 1'b1;
        @(negedge clk);
        chk("t4_kclk", 64'(kclk), 64'd0);
        chk("t4_key", 64'(key), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_found", 64'(found), 64'd0);
        rstn = 1'b1; core_rst = 1'b0;
        wait_found("t4_wait");
        chk("t4_idx", 64'(idx), 64'd2);
        chk("t4_key_reread", 64'(key), 64'h0F0F_1E1E_8001);
        pulse_ack();
        core_valid = '0;
        do_reset();

        // Core 0 keyed, others exhaust during the transfer
        key_table[0] = 48'h8000_0000_0001;
        do_reset();
        core_valid[0] = 1'b1; core_done[0] = 1'b1;
        repeat (10) @(negedge clk);
        core_done = '1;
        wait_found("t5_wait");
        chk("t5_idx", 64'(idx), 64'd0);
        chk("t5_key", 64'(key), 64'h8000_0000_0001);
        pulse_ack();
        @(negedge clk);
        chk("t5_exhaust", 64'(sdone), 64'd1);
        chk("t5_nofound", 64'(found), 64'd0);
        core_valid = '0; core_done = '0;
        do_reset();

        // ACK during the transfer is ignored
        key_table[7] = 48'h7777_0000_ABCD;
        do_reset();
        core_valid[7] = 1'b1;
        repeat (10) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        wait_found("t6_wait");
        chk("t6_idx", 64'(idx), 64'd7);
        chk("t6_key", 64'(key), 64'h7777_0000_ABCD);
        pulse_ack();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/crypto1_key_collector.md
Name: crypto1_key_collector

Overview:
- Downstream of the Crypto1Core array. Monitors each core's DONE/KEY_VALID.
- Selects the first core that reports a key and clocks its 48-bit key out over that core's serial KEY_DATA/KEY_CLK interface.
- Presents the assembled key and search status to the host-side register block.
- Also reports search-exhausted when every core is DONE and none has a key.

Parameters:
- NCORES, 16, number of Crypto1Core instances attached; 1..64.
- KEY_W, 48, key width in bits; fixed at 48, exposed for readability only.

Ports:
- CLK  input  1  system clock
- RESETn  input  1  synchronous active-low reset
- CORE_DONE  input  NCORES  DONE from each core, bit i = core i
- CORE_KEY_VALID  input  NCORES  KEY_VALID from each core
- CORE_KEY_DATA  input  NCORES  KEY_DATA from each core
- CORE_KEY_CLK  output  NCORES  per-core key shift enable, registered, at most one bit set
- KEY  output  KEY_W  recovered key, MSB first as shifted
- KEY_FOUND  output  1  KEY holds a valid recovered key
- CORE_IDX  output  $clog2(NCORES)+1  index of the core that supplied KEY
- SEARCH_DONE  output  1  search concluded, key found or space exhausted
- BUSY  output  1  high in SHIFT/DRAIN
- ACK  input  1  host acknowledge; returns block to SCAN

Behaviour:
- Reset values: CORE_KEY_CLK=0, KEY=0, KEY_FOUND=0, CORE_IDX=0, SEARCH_DONE=0, BUSY=0, state=SCAN, bit counter=0.
- Inputs are used directly; cores share CLK.
- State SCAN:
  - If any CORE_KEY_VALID bit is set, latch sel = lowest set index, go to SHIFT. Lowest index wins on simultaneous valids.
  - Else if all CORE_DONE bits are 1, set SEARCH_DONE=1, KEY_FOUND=0, go to REPORT.
  - KEY_VALID takes priority over the all-done check in the same cycle.
- State SHIFT:
  - CORE_KEY_CLK[sel]=1 on exactly 48 consecutive cycles (counter 0..47), all other bits 0.
  - Go to DRAIN after the 48th cycle.
- Key timing: the core updates KEY_DATA on the edge where it sees KEY_CLK high, so bit (47-i) is valid on CORE_KEY_DATA[sel] two cycles after CORE_KEY_CLK cycle i is driven.
- Shift register: KEY <= {KEY[46:0], CORE_KEY_DATA[sel]}. It runs for 48 cycles, starting 2 cycles after the first CORE_KEY_CLK cycle, controlled by a 2-cycle delayed copy of the shift enable.
- State DRAIN: covers the 2-cycle tail. After the 48th shift-in:
  - KEY_FOUND=1, SEARCH_DONE=1, CORE_IDX=sel;
  - go to REPORT.
- Latency from KEY_VALID seen in SCAN to KEY_FOUND=1 is 51 cycles:
  - 1 cycle select;
  - 48 cycles of CORE_KEY_CLK;
  - 2 cycles of pipeline.
- BUSY=1 in SHIFT and DRAIN only.
- State REPORT:
  - Outputs held stable.
  - On ACK=1, clear SEARCH_DONE, KEY_FOUND and KEY, and return to SCAN.
  - A core already read is not re-read: sel is recorded in a "consumed" mask and masked from KEY_VALID in later SCANs.
  - The exhausted condition re-asserts immediately if all cores are still DONE and no unconsumed key remains.
- ACK outside REPORT is ignored.
- Other cores that finish during SHIFT/DRAIN are ignored until the next SCAN. Their KEY_VALID stays high, since cores hold state.
- A KEY_VALID bit dropping during SHIFT does not abort the transfer. Behaviour is only defined for stable cores.
- Reset mid-operation: all state, the consumed mask and outputs return to reset values in the next cycle. CORE_KEY_CLK is deasserted in the same cycle reset is sampled.
- Bit counter: 6 bits, no wrap; terminates exactly at 47.
- Invariant: at most one CORE_KEY_CLK bit is high in any cycle; the bench asserts this.

Test Plan:
- Core 3 holds key 48'hA5A5_5A5A_C3C3 and raises KEY_VALID at cycle 10; no other core done.
  - Required: CORE_KEY_CLK[3] high for cycles 11..58, only that bit set.
  - Required: KEY=48'hA5A5_5A5A_C3C3, KEY_FOUND=1, CORE_IDX=3, SEARCH_DONE=1 at cycle 61.
- All 16 CORE_DONE rise with no KEY_VALID.
  - Required: SEARCH_DONE=1 and KEY_FOUND=0 the next cycle.
  - Required: CORE_KEY_CLK never asserted, KEY=0.
- Cores 5 and 9 raise KEY_VALID in the same cycle.
  - Required: CORE_IDX=5 and core 5's key returned.
  - After ACK: core 9 is read next, CORE_IDX=9.
- RESETn=0 for 1 cycle at counter=20 of SHIFT.
  - Required: CORE_KEY_CLK=0 and all outputs at reset values next cycle.
  - Required: a fresh SCAN re-reads a re-reset core model correctly.
- Core 0 reports key while cores 1..15 still running; cores 1..15 go DONE without key during SHIFT.
  - Required: key from core 0 reported; after ACK, SEARCH_DONE=1 with KEY_FOUND=0.
- ACK pulsed during SHIFT.
  - Required: ignored; transfer completes and KEY_FOUND=1 as normal.
